// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the AHB-to-APB bridge sequencer.
// Contents: FSM state enum, request-entry payload, default sizing, select decode.
package apb_bridge_pkg;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_NSLV  = 4;
  localparam int unsigned DEF_TMO   = 16;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_SEL_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              write;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  // One-hot decode of a peripheral index; callers truncate to their select width.
  function automatic logic [31:0] sel_onehot(input logic [MAX_SEL_W-1:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/bridge_req_fifo.sv
// Synchronous request FIFO, power-of-2 depth, head visible combinationally.
// Ports: Hclk/Hresetn (sync active-low), push/wdata, pop/rdata_c,
//        full_c/empty_c status, count occupancy register.
module bridge_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 65
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rdata_c = mem[rd_ptr];

  // Storage array, no reset needed: contents are qualified by count.
  always_ff @(posedge Hclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// APB-side sequencer of the AHB-to-APB bridge: queues front-end transfers and
// drains them as APB SETUP/ACCESS cycles with wait-state timeout.
// Ports: Hclk/Hresetn (sync active-low); front-end valid/Haddr_temp/Hwdata_temp/
//        Hwrite_temp; APB Pready/Prdata/Pslverr in, Psel/Penable/Pwrite/Paddr/
//        Pwdata out; AHB-side Hreadyout/Hrdata/Hresp and sticky ovf out.
module apb_bridge_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned NSLV    = DEF_NSLV,
  parameter int unsigned SEL_LSB = 28,
  parameter int unsigned TMO     = DEF_TMO
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  input  logic            valid,
  input  logic [31:0]     Haddr_temp,
  input  logic [31:0]     Hwdata_temp,
  input  logic            Hwrite_temp,
  input  logic            Pready,
  input  logic [31:0]     Prdata,
  input  logic            Pslverr,
  output logic            Hreadyout,
  output logic [31:0]     Hrdata,
  output logic            Hresp,
  output logic            ovf,
  output logic [NSLV-1:0] Psel,
  output logic            Penable,
  output logic            Pwrite,
  output logic [31:0]     Paddr,
  output logic [31:0]     Pwdata
);

  localparam int unsigned SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WCNT_W = $clog2(TMO);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TMO - 1);

  apb_state_e        state;
  apb_state_e        state_nxt;
  req_t              req_in;
  req_t              head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              push_c;
  logic              pop_c;
  logic              xfer_end_c;

  logic [WCNT_W-1:0] wcnt;
  logic              rd_pend;

  logic [NSLV-1:0]   psel_nxt;
  logic              penable_nxt;
  logic              pwrite_nxt;
  logic [31:0]       paddr_nxt;
  logic [31:0]       pwdata_nxt;
  logic [31:0]       hrdata_nxt;
  logic              hresp_nxt;
  logic              hreadyout_nxt;
  logic              ovf_nxt;
  logic [WCNT_W-1:0] wcnt_nxt;
  logic              rd_pend_nxt;
  logic [CNT_W-1:0]  count_nxt;

  assign req_in = '{addr: Haddr_temp, data: Hwdata_temp, write: Hwrite_temp};

  // An outstanding read blocks further pushes; those are dropped as overflow.
  assign push_c     = valid && !fifo_full_c && !rd_pend;
  // ACCESS ends on ready, or on the last permitted wait cycle (abort).
  assign xfer_end_c = (state == ACCESS) && (Pready || (wcnt == WCNT_MAX));
  assign pop_c      = !fifo_empty_c && ((state == IDLE) || xfer_end_c);

  bridge_req_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W)
  ) u_req_fifo (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (req_in),
    .rdata_c (head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

  // State and output registers.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state     <= IDLE;
      Psel      <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hrdata    <= '0;
      Hresp     <= 1'b0;
      Hreadyout <= 1'b1;
      ovf       <= 1'b0;
      wcnt      <= '0;
      rd_pend   <= 1'b0;
    end else begin
      state     <= state_nxt;
      Psel      <= psel_nxt;
      Penable   <= penable_nxt;
      Pwrite    <= pwrite_nxt;
      Paddr     <= paddr_nxt;
      Pwdata    <= pwdata_nxt;
      Hrdata    <= hrdata_nxt;
      Hresp     <= hresp_nxt;
      Hreadyout <= hreadyout_nxt;
      ovf       <= ovf_nxt;
      wcnt      <= wcnt_nxt;
      rd_pend   <= rd_pend_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty_c) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_end_c) state_nxt = fifo_empty_c ? IDLE : SETUP;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    psel_nxt    = Psel;
    penable_nxt = Penable;
    pwrite_nxt  = Pwrite;
    paddr_nxt   = Paddr;
    pwdata_nxt  = Pwdata;
    hrdata_nxt  = Hrdata;
    hresp_nxt   = 1'b0;
    wcnt_nxt    = wcnt;
    rd_pend_nxt = rd_pend;
    ovf_nxt     = ovf | (valid & (fifo_full_c | rd_pend));

    case (state)
      SETUP: penable_nxt = 1'b1;
      ACCESS: begin
        if (!Pready && (wcnt != WCNT_MAX)) wcnt_nxt = wcnt + WCNT_W'(1);
        if (xfer_end_c) begin
          // A timeout reports as an error and returns zero read data.
          hresp_nxt   = Pready ? Pslverr : 1'b1;
          psel_nxt    = '0;
          penable_nxt = 1'b0;
          if (!Pwrite) begin
            hrdata_nxt  = Pready ? Prdata : '0;
            rd_pend_nxt = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // Popping the head starts a SETUP phase (from IDLE or back-to-back).
    if (pop_c) begin
      paddr_nxt   = head_c.addr;
      pwdata_nxt  = head_c.data;
      pwrite_nxt  = head_c.write;
      psel_nxt    = NSLV'(sel_onehot(MAX_SEL_W'(head_c.addr[SEL_LSB +: SEL_W])));
      penable_nxt = 1'b0;
      wcnt_nxt    = '0;
    end

    if (push_c && !Hwrite_temp) rd_pend_nxt = 1'b1;

    count_nxt     = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    hreadyout_nxt = (count_nxt != CNT_W'(DEPTH)) && !rd_pend_nxt;
  end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Scoreboard bench for apb_bridge_ctrl: stimulus queues expected APB transfers
// and responses; a monitor checks each SETUP/ACCESS/response the DUT presents,
// while a responder drives Pready/Prdata/Pslverr per queued transfer.
module tb_apb_bridge_ctrl;

  localparam int unsigned TMO_C = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [3:0]  psel;
    int unsigned wt;
    logic        err;
    logic [31:0] rdata;
  } xfer_t;

  logic        Hclk;
  logic        Hresetn;
  logic        valid;
  logic [31:0] Haddr_temp;
  logic [31:0] Hwdata_temp;
  logic        Hwrite_temp;
  logic        Pready;
  logic [31:0] Prdata;
  logic        Pslverr;
  logic        Hreadyout;
  logic [31:0] Hrdata;
  logic        Hresp;
  logic        ovf;
  logic [3:0]  Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  xfer_t exp_q[$];
  xfer_t rsp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  apb_bridge_ctrl #(
    .DEPTH   (4),
    .NSLV    (4),
    .SEL_LSB (28),
    .TMO     (TMO_C)
  ) dut (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .valid       (valid),
    .Haddr_temp  (Haddr_temp),
    .Hwdata_temp (Hwdata_temp),
    .Hwrite_temp (Hwrite_temp),
    .Pready      (Pready),
    .Prdata      (Prdata),
    .Pslverr     (Pslverr),
    .Hreadyout   (Hreadyout),
    .Hrdata      (Hrdata),
    .Hresp       (Hresp),
    .ovf         (ovf),
    .Psel        (Psel),
    .Penable     (Penable),
    .Pwrite      (Pwrite),
    .Paddr       (Paddr),
    .Pwdata      (Pwdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_psel"},      32'(Psel),      32'h0);
    chk({tag, "_penable"},   32'(Penable),   32'h0);
    chk({tag, "_pwrite"},    32'(Pwrite),    32'h0);
    chk({tag, "_paddr"},     Paddr,          32'h0);
    chk({tag, "_pwdata"},    Pwdata,         32'h0);
    chk({tag, "_hrdata"},    Hrdata,         32'h0);
    chk({tag, "_hresp"},     32'(Hresp),     32'h0);
    chk({tag, "_ovf"},       32'(ovf),       32'h0);
    chk({tag, "_hreadyout"}, 32'(Hreadyout), 32'h1);
  endtask

  // Drive one front-end strobe; queue expectations only for accepted transfers.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input logic [3:0] ps, input int unsigned wt, input logic er,
                       input logic [31:0] rd, input bit accepted);
    xfer_t x;
    valid       = 1'b1;
    Haddr_temp  = a;
    Hwdata_temp = d;
    Hwrite_temp = wr;
    x.addr = a; x.data = d; x.wr = wr; x.psel = ps; x.wt = wt; x.err = er; x.rdata = rd;
    if (accepted) begin
      exp_q.push_back(x);
      rsp_q.push_back(x);
    end
  endtask

  task automatic drain(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge Hclk);
      if (exp_q.size() == 0 && Psel == 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(ok), 32'h1);
    repeat (2) @(negedge Hclk);
  endtask

  // Responder: Pready rises after wt low ACCESS cycles (never if wt >= TMO).
  initial begin : responder
    xfer_t       r;
    bit          have;
    int unsigned racc;
    Pready = 1'b0; Prdata = '0; Pslverr = 1'b0; have = 1'b0; racc = 0;
    forever begin
      @(negedge Hclk);
      if (!Hresetn) begin
        rsp_q.delete();
        have = 1'b0; Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
        continue;
      end
      if (Psel != 4'b0 && !Penable) begin
        have = 1'b0; racc = 0; Pready = 1'b0; Pslverr = 1'b0;
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          have = 1'b1;
        end
      end else if (Psel != 4'b0 && Penable && have) begin
        racc++;
        Pready  = (racc > r.wt);
        Pslverr = Pready && r.err;
        Prdata  = Pready ? r.rdata : 32'hBAD0_0BAD;
      end else begin
        Pready = 1'b0; Pslverr = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    xfer_t       cur;
    bit          exp_acc, pend, pend_err, pend_rd, tmo;
    logic [31:0] pend_rdata;
    int unsigned acc;
    exp_acc = 1'b0; pend = 1'b0; pend_err = 1'b0; pend_rd = 1'b0; tmo = 1'b0;
    pend_rdata = '0; acc = 0;
    cur = '{addr: '0, data: '0, wr: 1'b0, psel: '0, wt: 0, err: 1'b0, rdata: '0};
    forever begin
      @(negedge Hclk);
      if (!Hresetn) begin
        exp_q.delete();
        exp_acc = 1'b0; pend = 1'b0;
        continue;
      end
      if (pend || Hresp) chk("hresp", 32'(Hresp), 32'(pend && pend_err));
      if (pend && pend_rd) begin
        chk("hrdata", Hrdata, pend_rdata);
        chk("hreadyout_after_read", 32'(Hreadyout), 32'h1);
      end
      pend = 1'b0;
      if (Psel != 4'b0 && Penable) begin
        chk("access_legal", 32'(exp_acc), 32'h1);
        if (exp_acc) begin
          acc++;
          chk("paddr_stable", Paddr, cur.addr);
          chk("psel_stable", 32'(Psel), 32'(cur.psel));
          if (acc > cur.wt || acc == TMO_C) begin
            tmo        = (acc == TMO_C) && (cur.wt >= TMO_C);
            pend       = 1'b1;
            pend_err   = tmo || cur.err;
            pend_rd    = !cur.wr;
            pend_rdata = tmo ? 32'h0 : cur.rdata;
            exp_acc    = 1'b0;
          end
        end
      end else begin
        if (exp_acc) begin
          chk("access_present", 32'(Penable), 32'h1);
          exp_acc = 1'b0;
        end
        if (Psel != 4'b0) begin
          if (exp_q.size() == 0) begin
            chk("setup_expected", 32'(exp_q.size()), 32'h1);
          end else begin
            cur = exp_q.pop_front();
            chk("setup_psel", 32'(Psel), 32'(cur.psel));
            chk("setup_paddr", Paddr, cur.addr);
            chk("setup_pwrite", 32'(Pwrite), 32'(cur.wr));
            if (cur.wr) chk("setup_pwdata", Pwdata, cur.data);
            acc = 0;
            exp_acc = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int busy;
    Hresetn = 1'b0; valid = 1'b0; Haddr_temp = '0; Hwdata_temp = '0; Hwrite_temp = 1'b0;
    repeat (3) @(negedge Hclk);
    chk_reset("rst");
    Hresetn = 1'b1;
    repeat (2) @(negedge Hclk);

    // Single write: Psel in n+2, Penable in n+3.
    issue(32'h1000_0004, 32'hA5A5_0001, 1'b1, 4'b0010, 0, 1'b0, 32'h0, 1'b1);
    @(negedge Hclk); valid = 1'b0;
    chk("t1_psel_n1", 32'(Psel), 32'h0);
    @(negedge Hclk);
    chk("t1_psel_n2", 32'(Psel), 32'h2);
    chk("t1_penable_n2", 32'(Penable), 32'h0);
    @(negedge Hclk);
    chk("t1_penable_n3", 32'(Penable), 32'h1);
    chk("t1_pwdata", Pwdata, 32'hA5A5_0001);
    chk("t1_hreadyout", 32'(Hreadyout), 32'h1);
    drain(20);

    // Back-to-back burst: 8 contiguous APB cycles, Hreadyout never drops.
    for (int i = 0; i < 4; i++) begin
      issue(32'(i), 32'hB000_0000 + 32'(i), 1'b1, 4'b0001, 0, 1'b0, 32'h0, 1'b1);
      @(negedge Hclk);
      chk("t2_hreadyout", 32'(Hreadyout), 32'h1);
    end
    valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("t2_no_gap", 32'(Psel != 4'b0), 32'h1);
      @(negedge Hclk);
    end
    chk("t2_end_idle", 32'(Psel), 32'h0);
    drain(20);

    // Read with 3 wait states: Hreadyout low until the cycle after completion.
    issue(32'h2000_0010, 32'h0, 1'b0, 4'b0100, 3, 1'b0, 32'hDEAD_BEEF, 1'b1);
    @(negedge Hclk); valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("t3_hreadyout_low", 32'(Hreadyout), 32'h0);
      @(negedge Hclk);
    end
    chk("t3_hreadyout_high", 32'(Hreadyout), 32'h1);
    chk("t3_hrdata", Hrdata, 32'hDEAD_BEEF);
    drain(20);

    // Overflow: first entry stalls, 4 more fill the FIFO, the 6th is dropped.
    for (int i = 0; i < 6; i++) begin
      issue(32'h3000_0000 + 32'(4 * i), 32'h0000_1100 + 32'(i), 1'b1, 4'b1000,
            (i == 0) ? 5 : 0, 1'b0, 32'h0, i < 5);
      @(negedge Hclk);
      if (i == 3) chk("t4_hreadyout_before_full", 32'(Hreadyout), 32'h1);
      if (i == 4) begin
        chk("t4_hreadyout_full", 32'(Hreadyout), 32'h0);
        chk("t4_ovf_before", 32'(ovf), 32'h0);
      end
      if (i == 5) chk("t4_ovf_after", 32'(ovf), 32'h1);
    end
    valid = 1'b0;
    drain(40);
    chk("t4_ovf_sticky", 32'(ovf), 32'h1);
    chk("t4_hreadyout_recovered", 32'(Hreadyout), 32'h1);

    // Timeout abort, then next entry; boundary wait of TMO-1 completes cleanly.
    issue(32'h0000_0100, 32'hC000_0001, 1'b1, 4'b0001, 99, 1'b0, 32'h0, 1'b1);
    @(negedge Hclk);
    issue(32'h1000_0200, 32'hC000_0002, 1'b1, 4'b0010, 0, 1'b0, 32'h0, 1'b1);
    @(negedge Hclk); valid = 1'b0;
    drain(60);
    issue(32'h2000_0300, 32'hC000_0003, 1'b1, 4'b0100, TMO_C - 1, 1'b0, 32'h0, 1'b1);
    @(negedge Hclk); valid = 1'b0;
    drain(40);
    // Read timeout returns zero data.
    issue(32'h3000_0008, 32'h0, 1'b0, 4'b1000, 99, 1'b0, 32'h1234_5678, 1'b1);
    @(negedge Hclk); valid = 1'b0;
    drain(40);
    // Slave error.
    issue(32'h1000_0000, 32'hE000_0001, 1'b1, 4'b0010, 1, 1'b1, 32'h0, 1'b1);
    @(negedge Hclk); valid = 1'b0;
    drain(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    // Reset during ACCESS with 2 entries queued.
    issue(32'h0000_0040, 32'hF000_0001, 1'b1, 4'b0001, 10, 1'b0, 32'h0, 1'b1);
    @(negedge Hclk);
    issue(32'h1000_0044, 32'hF000_0002, 1'b1, 4'b0010, 0, 1'b0, 32'h0, 1'b1);
    @(negedge Hclk);
    issue(32'h2000_0048, 32'hF000_0003, 1'b1, 4'b0100, 0, 1'b0, 32'h0, 1'b1);
    @(negedge Hclk); valid = 1'b0;
    @(negedge Hclk);
    chk("t6_in_access", 32'(Penable), 32'h1);
    Hresetn = 1'b0;
    @(negedge Hclk);
    chk_reset("t6");
    @(negedge Hclk);
    Hresetn = 1'b1;
    busy = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge Hclk);
      if (Psel != 4'b0 || Penable || Hresp) busy++;
    end
    chk("t6_no_apb_after_reset", 32'(busy), 32'h0);
    chk("t6_hreadyout", 32'(Hreadyout), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_bridge_ctrl.md
# apb_bridge_ctrl

Sequencer for the APB side of the AHB-to-APB bridge. It buffers the transfers captured by the AHB slave front-end (`valid`, `Haddr_temp`, `Hwdata_temp`, `Hwrite_temp`) in a small request FIFO and drains them as APB SETUP/ACCESS cycles. It decodes one of `NSLV` peripheral selects, applies wait-state and timeout handling, and returns read data and stall/error status to the AHB side.

## Interface
Reset is synchronous and active-low; there is one clock, `Hclk`, and reset is `Hresetn`.

Parameters:
- `DEPTH`, 4: request FIFO entries (power of 2, ≥2).
- `NSLV`, 4: APB peripherals (power of 2).
- `SEL_LSB`, 28: lowest address bit of the peripheral-select field (`log2(NSLV)` bits wide).
- `TMO`, 16: maximum ACCESS cycles with `Pready` low before abort.

Ports:
- `Hclk` in 1: clock.
- `Hresetn` in 1: synchronous active-low reset.
- `valid` in 1: front-end transfer strobe, one transfer per high cycle.
- `Haddr_temp` in 32: transfer address.
- `Hwdata_temp` in 32: write data.
- `Hwrite_temp` in 1: 1 = write, 0 = read.
- `Pready` in 1: APB ready.
- `Prdata` in 32: APB read data.
- `Pslverr` in 1: APB slave error.
- `Hreadyout` out 1: 0 stalls the AHB side.
- `Hrdata` out 32: read return data.
- `Hresp` out 1: error pulse, 1 cycle.
- `ovf` out 1: sticky overflow flag.
- `Psel` out NSLV: one-hot peripheral select.
- `Penable` out 1: APB enable.
- `Pwrite` out 1: APB direction.
- `Paddr` out 32: APB address.
- `Pwdata` out 32: APB write data.

## Operation
- **FIFO push:** an entry `{addr, data, write}` is pushed on every edge where `valid`=1 and the FIFO is not full.
- **Overflow:** `valid`=1 while full drops the transfer and sets `ovf`. `ovf` clears only on reset.
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE → SETUP when the FIFO is non-empty. On the same edge the head is popped into the `Paddr`/`Pwdata`/`Pwrite` registers, and `Psel[Paddr[SEL_LSB +: log2(NSLV)]]` is set.
  - SETUP → ACCESS unconditionally; `Penable` goes to 1.
  - ACCESS with `Pready`=1 completes the transfer. It then goes to SETUP with the next head if the FIFO is non-empty (back-to-back transfer, `Psel` re-decoded, `Penable` to 0). Otherwise it goes to IDLE with `Psel` and `Penable` at 0.
  - ACCESS with `Pready`=0 holds state and increments the wait counter. When the counter reaches `TMO-1` the transfer is aborted: the FSM exits as on completion and the transfer is treated as an error.
- **Wait counter:** width `$clog2(TMO)`, cleared on entering SETUP, saturates at `TMO-1`.
- **Completion of a read:** `Hrdata` ← `Prdata` (0 on timeout), and the outstanding-read flag clears.
- **Errors:** a completion with `Pslverr`=1, or a timeout, pulses `Hresp` high for 1 cycle.
- **Writes are posted:** they never stall beyond a full FIFO.
- **Reads:** pushing a read sets the outstanding-read flag. While it is set, `Hreadyout`=0 and any further `valid` is treated as overflow.
- **`Hreadyout` =** !full && !read_outstanding, registered.
- **Push and pop on the same edge:** both happen and the count is unchanged. Pushing into an empty FIFO while the FSM is in IDLE takes effect next edge, with no bypass.

## Timing
- **Reset values:** all outputs 0 except `Hreadyout`=1. FSM = IDLE, FIFO empty, wait counter 0, read flag 0, `ovf` 0.
- **Reset mid-transfer:** reset asserted during SETUP or ACCESS drops `Psel`/`Penable` on the next edge and discards FIFO contents, with no `Hresp` pulse.
- **Write latency:** with `valid` high in cycle n, the FIFO is non-empty in n+1, `Psel` is high in n+2 (SETUP), and `Penable` is high in n+3 (ACCESS).
- **Zero-wait transfer:** one SETUP plus one ACCESS cycle. A zero-wait stream of k transfers occupies 2k cycles.
- **Read return:** with `Pready` high in ACCESS cycle m, `Hrdata` is valid and `Hreadyout`=1 in m+1.
- **APB stability:** `Paddr`/`Pwdata`/`Pwrite`/`Psel` stay stable from SETUP through the last ACCESS cycle.
- **Timeout:** with `Pready` held low, the abort edge is the end of the `TMO`-th ACCESS cycle, and `Hresp` is high in the following cycle.

## Structure
- **Shared package `apb_bridge_pkg`:**
  - FSM state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10).
  - Request-entry struct `{addr[31:0], data[31:0], write}`.
  - Default `TMO`/`DEPTH` constants.
  - One-hot select decode function.
- **Sub-module `bridge_req_fifo`:** synchronous FIFO parameterised by `DEPTH` and entry width, with push/pop/full/empty/count. The FSM, counter and output registers stay in the top.

## Test plan
- **Single write:** `valid`=1, addr 0x1000_0004, data 0xA5A5_0001, write=1, `Pready`=1. Expect `Psel`=4'b0010 in n+2, `Penable` in n+3, `Pwdata`=0xA5A5_0001, `Hresp`=0, `Hreadyout` stays 1.
- **Back-to-back burst:** 4 consecutive writes to 0x0000_0000..0x0000_0003, `Pready`=1. Expect 8 APB cycles with alternating SETUP/ACCESS, no IDLE gap, and the FIFO never full.
- **Read with wait states:** read of 0x2000_0010 with `Pready` low for 3 ACCESS cycles, `Prdata`=0xDEAD_BEEF. Expect `Hreadyout`=0 until the cycle after completion, then `Hrdata`=0xDEAD_BEEF.
- **Overflow:** `Pready` held 0 and 6 consecutive writes with DEPTH=4. Expect `Hreadyout`=0 once full and `ovf`=1 after the 6th write. The accepted entries drain in order once `Pready`=1.
- **Timeout and slave error:** `Pready` stuck 0 gives an abort after 16 ACCESS cycles, a 1-cycle `Hresp` pulse, and the next entry starting SETUP. A separate transfer with `Pslverr`=1 and `Pready`=1 gives a `Hresp` pulse.
- **Reset mid-transfer:** `Hresetn`=0 during ACCESS with 2 entries queued. Expect all outputs at reset values next cycle, no APB activity after release, and `Hreadyout`=1.
